// File: rtl/pq_pkg.sv
// Shared definitions for the sample-processing blocks that time-share the
// constant-gain multiplier: scheduler states, the multiplier's fixed gain and
// shift, the post-reset flush length and a width helper.
package pq_pkg;

    typedef enum logic [1:0] {
        DRAIN,
        IDLE,
        ISSUE,
        WAIT
    } sched_state_t;

    localparam logic [15:0] MUL_GAIN  = 16'h08B4;
    localparam int          MUL_SHIFT = 4;

    // Number of cycles the multiplier needs to settle after the scheduler
    // is reset, since the multiplier has no reset of its own.
    localparam int DRAIN_CYC = 4;

    // Bits needed to hold values 0..n-1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_scheduler_if.sv
// Request/result bus between the sample sources and the multiplier scheduler.
//   req_valid / req_data / req_ready : per-channel sample handshake
//   res_valid / res_data             : per-channel result pulse + shared result
// master = sample sources, slave = scheduler.
interface mul_scheduler_if #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 16,
    parameter int RES_W  = 24
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        res_valid;
    logic [RES_W-1:0]        res_data;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  res_valid,
        input  res_data
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output res_valid,
        output res_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   valid : per-channel request
//   last  : index granted most recently; search starts at last+1
//   grant : one-hot grant of the chosen channel (zero when nothing requests)
//   idx   : index of the chosen channel
//   found : at least one channel is requesting
module rr_arbiter
    import pq_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Walk the channels in priority order last+1, last+2, ... wrapping at
    // N_REQ; the first requester wins and later ones are masked by found.
    always_comb begin
        int c;
        logic [IDX_W-1:0] cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            c = int'(last) + i;
            if (c >= N_REQ) begin
                c = c - N_REQ;
            end
            cand = IDX_W'(c);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mul_scheduler.sv
// Round-robin scheduler sharing one constant-gain multiplier between N_REQ
// sample sources. Each accepted sample is issued to the multiplier with a
// one-cycle en pulse; the result is returned tagged with its source channel.
// A watchdog flags a missing done, and a drain phase after reset lets the
// (unreset) multiplier finish any operation it was in the middle of.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : sample handshake and tagged result (slave side)
//   mul_a     : multiplier operand, mul_en : multiplier start
//   mul_out   : multiplier result, mul_done : multiplier done
//   busy      : high in every state except IDLE
//   err       : sticky watchdog flag
module mul_scheduler
    import pq_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int DATA_W  = 16,
    parameter int RES_W   = 24,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    mul_scheduler_if.slave    bus,
    output logic [DATA_W-1:0] mul_a,
    output logic              mul_en,
    input  logic [RES_W-1:0]  mul_out,
    input  logic              mul_done,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = clog2(N_REQ);
    localparam int WD_W  = clog2(TIMEOUT + 1);
    localparam int DR_W  = clog2(DRAIN_CYC);

    sched_state_t     state;
    logic [DR_W-1:0]  drain_cnt;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] ch;
    logic [WD_W-1:0]  wdog;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] pick;
    logic             found;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .valid (bus.req_valid),
        .last  (last),
        .grant (grant),
        .idx   (pick),
        .found (found)
    );

    // Grants are only offered while idle, so at most one sample is accepted
    // per multiplier operation.
    assign bus.req_ready = (state == IDLE) ? grant : '0;
    assign busy          = (state != IDLE);

    // mul_a only changes on an accepted handshake in IDLE, which keeps the
    // operand stable from ISSUE until after done. Going through IDLE before
    // the next ISSUE also keeps en away from the multiplier's finish cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= DRAIN;
            drain_cnt     <= DR_W'(DRAIN_CYC - 1);
            last          <= IDX_W'(N_REQ - 1);
            ch            <= '0;
            wdog          <= '0;
            mul_en        <= 1'b0;
            mul_a         <= '0;
            err           <= 1'b0;
            bus.res_valid <= '0;
            bus.res_data  <= '0;
        end else begin
            bus.res_valid <= '0;
            case (state)
                DRAIN: begin
                    drain_cnt <= drain_cnt - 1'b1;
                    if (drain_cnt == '0) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (found) begin
                        mul_a  <= bus.req_data[pick*DATA_W +: DATA_W];
                        ch     <= pick;
                        last   <= pick;
                        mul_en <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_en <= 1'b0;
                    wdog   <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    // done takes priority over a watchdog expiry in the same cycle
                    if (mul_done) begin
                        bus.res_data  <= mul_out;
                        bus.res_valid <= N_REQ'(1) << ch;
                        state         <= IDLE;
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    state <= DRAIN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_scheduler.sv
// Self-checking bench for mul_scheduler. A behavioural multiplier stub with a
// selectable done delay (or none) drives the multiplier side; a cycle-level
// reference model predicts grants, mul_en, busy, results and err from the
// scheduling rules and the gain arithmetic.
module tb_mul_scheduler;
    import pq_pkg::*;

    localparam int N_REQ   = 3;
    localparam int DATA_W  = 16;
    localparam int RES_W   = 24;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1 << 30;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] mul_a;
    logic              mul_en;
    logic [RES_W-1:0]  mul_out;
    logic              mul_done;
    logic              busy;
    logic              err;

    logic [N_REQ-1:0]        vld;
    logic [N_REQ*DATA_W-1:0] dat;

    mul_scheduler_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .RES_W(RES_W)) bus ();

    assign bus.req_valid = vld;
    assign bus.req_data  = dat;

    mul_scheduler #(
        .N_REQ   (N_REQ),
        .DATA_W  (DATA_W),
        .RES_W   (RES_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mul_a    (mul_a),
        .mul_en   (mul_en),
        .mul_out  (mul_out),
        .mul_done (mul_done),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gain multiply on a sign-magnitude sample.
    function automatic logic [RES_W-1:0] ref_mul(input logic [DATA_W-1:0] a);
        logic [31:0] p;
        p = (32'(a[DATA_W-2:0]) * 32'(MUL_GAIN)) >> MUL_SHIFT;
        return {a[DATA_W-1], p[RES_W-2:0]};
    endfunction

    // Multiplier stub without reset: done arrives mul_delay cycles after the
    // cycle following en; mul_delay = 0 models a hung multiplier.
    int          mul_delay = 3;
    int          stub_cnt  = 0;
    logic        op_pend   = 1'b0;
    logic [15:0] op        = '0;

    always @(posedge clk) begin
        op_pend <= mul_en;
        if (op_pend) op <= mul_a;
        if (mul_en && mul_delay > 0) stub_cnt <= mul_delay;
        else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
    end

    assign mul_done = (stub_cnt == 1);
    assign mul_out  = ref_mul(op);

    int   cyc = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    int               next_free = NEVER;
    int               en_cycle  = -1;
    int               res_cycle = -1;
    int               err_cycle = NEVER;
    int               res_ch_m  = 0;
    int               last_m    = N_REQ - 1;
    logic [RES_W-1:0] res_val_m = '0;
    logic [RES_W-1:0] res_data_m = '0;
    logic             hs = 1'b0;
    int               hs_ch = 0;

    // Stimulus control
    int   stim_mode      = 4;
    int   phase_start    = 0;
    int   rst_hold_until = 2;
    int   rst_at         = -1;
    logic rst_once       = 1'b0;
    logic served0        = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int cur);
        logic granted;
        rst = (cur <= rst_hold_until) || (cur == rst_at);
        if (hs && hs_ch == 0) served0 = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            granted = hs && (hs_ch == i);
            case (stim_mode)
                0: begin
                    if (vld[i] && !granted) begin
                        if ($urandom_range(15) == 0) vld[i] = 1'b0;
                    end else if ($urandom_range(2) == 0) begin
                        vld[i] = 1'b1;
                        dat[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                    end else begin
                        vld[i] = 1'b0;
                    end
                end
                1: begin
                    vld[i] = 1'b1;
                    dat[i*DATA_W +: DATA_W] = (i == 0) ? 16'h0100 : (i == 1) ? 16'h8100 : 16'h7FFF;
                end
                2, 3, 5: begin
                    if (i == 0) begin
                        vld[0] = (stim_mode == 5) ? 1'b1 : !served0;
                        dat[0 +: DATA_W] = 16'h0100;
                    end else if (i == 1 && stim_mode == 3) begin
                        vld[1] = (cur == phase_start + 3);
                        dat[DATA_W +: DATA_W] = 16'h1234;
                    end else begin
                        vld[i] = 1'b0;
                    end
                end
                default: vld[i] = 1'b0;
            endcase
        end
    endtask

    // Predicts and compares every output for cycle n.
    task automatic modelStep(input int n);
        logic [N_REQ-1:0] exp_ready;
        logic [N_REQ-1:0] exp_res_valid;
        int c;
        if (rst_q) begin
            next_free  = n + DRAIN_CYC;
            en_cycle   = -1;
            res_cycle  = -1;
            err_cycle  = NEVER;
            last_m     = N_REQ - 1;
            res_data_m = '0;
        end
        if (n == res_cycle) res_data_m = res_val_m;
        hs = 1'b0;
        exp_ready = '0;
        if (n >= next_free) begin
            for (int i = 1; i <= N_REQ; i++) begin
                c = (last_m + i) % N_REQ;
                if (!hs && vld[c]) begin
                    hs    = 1'b1;
                    hs_ch = c;
                end
            end
            if (hs) exp_ready[hs_ch] = 1'b1;
        end
        exp_res_valid = (n == res_cycle) ? (N_REQ'(1) << res_ch_m) : '0;

        checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        checkOutput("busy",      32'(busy),          32'(n < next_free));
        checkOutput("mul_en",    32'(mul_en),        32'(n == en_cycle));
        checkOutput("res_valid", 32'(bus.res_valid), 32'(exp_res_valid));
        checkOutput("res_data",  32'(bus.res_data),  32'(res_data_m));
        checkOutput("err",       32'(err),           32'(n >= err_cycle));

        if (hs) begin
            last_m   = hs_ch;
            en_cycle = n + 1;
            if (mul_delay > 0) begin
                res_cycle = n + mul_delay + 2;
                res_ch_m  = hs_ch;
                res_val_m = ref_mul(dat[hs_ch*DATA_W +: DATA_W]);
                next_free = res_cycle;
            end else begin
                next_free = n + TIMEOUT + 2;
                if (err_cycle > next_free) err_cycle = next_free;
            end
            if (stim_mode == 5 && !rst_once) begin
                rst_at   = n + 2;
                rst_once = 1'b1;
            end
        end
    endtask

    task automatic runCycles(input int mode, input int delay, input int count);
        stim_mode   = mode;
        mul_delay   = delay;
        phase_start = cyc;
        served0     = 1'b0;
        for (int k = 0; k < count; k++) begin
            @(posedge clk);
            #1;
            applyStimulus(cyc);
            @(negedge clk);
            modelStep(cyc);
        end
    endtask

    initial begin
        rst = 1'b1;
        vld = '0;
        dat = '0;

        runCycles(2, 3, 16);
        runCycles(1, 3, 32);
        runCycles(4, 3, 8);
        runCycles(0, 3, 200);
        runCycles(4, 3, 10);

        runCycles(2, 0, 22);
        runCycles(2, 3, 10);

        rst_hold_until = cyc + 2;
        runCycles(4, 3, 8);
        runCycles(2, 15, 24);
        runCycles(4, 3, 4);

        rst_once = 1'b0;
        runCycles(5, 3, 16);
        runCycles(4, 3, 8);

        runCycles(3, 3, 12);
        runCycles(0, 3, 150);
        runCycles(4, 3, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_scheduler.md
Name: mul_scheduler

Overview:
- Round-robin scheduler that shares the single constant-gain multiplier (`multiply`, gain 0x08B4, >>4, sign-magnitude 24-bit result) between N_REQ sample sources, for example the three phase-current channels.
- Accepts one sample per valid/ready handshake and drives the multiplier's en/done protocol.
- Returns each result tagged to its source channel.
- Flags multiplier hangs with a watchdog and flushes the multiplier after reset, because the multiplier itself has no reset.

Parameters:
- N_REQ, 3, number of requesting channels (2..8).
- DATA_W, 16, sample width (sign-magnitude, bit 15 is the sign).
- RES_W, 24, result width.
- TIMEOUT, 15, maximum WAIT cycles before done is declared missing.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-channel sample valid.
- req_data  in  N_REQ*DATA_W  packed samples; channel i occupies [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high at a clock edge.
- res_valid  out  N_REQ  one-cycle pulse, result available for channel i.
- res_data  out  RES_W  result of the most recent completed operation; held until the next completion.
- mul_a  out  DATA_W  multiplier operand.
- mul_en  out  1  multiplier start.
- mul_out  in  RES_W  multiplier result.
- mul_done  in  1  multiplier done.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky watchdog flag; cleared only by rst.

Behaviour:
- States: DRAIN, IDLE, ISSUE, WAIT.
- rst forces the following, from any state including mid-operation:
  - state=DRAIN, drain counter=3, last-grant pointer=N_REQ-1.
  - mul_en=0, req_ready=0, res_valid=0, res_data=0, mul_a=0, err=0.
- DRAIN:
  - mul_done is ignored; the counter decrements each cycle.
  - Go to IDLE after the cycle in which the counter reads 0, i.e. 4 cycles.
  - This guarantees the multiplier has returned to its idle state.
- IDLE, arbitration:
  - Search channels last+1, last+2, … modulo N_REQ.
  - The first channel with req_valid high gets req_ready high, combinationally, in the same cycle.
  - At that edge: capture req_data of the granted channel into mul_a, store the channel index, set last to that index, go to ISSUE.
  - With no request pending, stay in IDLE with req_ready=0.
- req_ready is asserted only in IDLE, so at most one handshake can occur per operation.
- ISSUE:
  - mul_en=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - mul_en=0; the watchdog counter increments each cycle.
  - If mul_done=1: register mul_out into res_data, pulse res_valid[ch] in the following cycle, go to IDLE.
  - Else, if the counter reaches TIMEOUT: set err=1, produce no res_valid, go to IDLE.
  - mul_done in the same cycle as the timeout: done wins, and err is not set.
- mul_a is held constant from ISSUE until the cycle after done is seen. The multiplier samples its operand one cycle after en.
- mul_en is never asserted in the cycle where mul_done=1. The multiplier ignores en in its finish cycle; the IDLE→ISSUE path provides the required spacing.
- Latency:
  - Handshake in cycle c0; mul_en in c1; mul_done in c4; res_valid pulse in c5.
  - Peak throughput is one result per 5 cycles.
- req_valid may drop without a grant; nothing is lost. Once req_valid is high, the source holds req_data until the handshake.
- mul_done outside WAIT, in IDLE or ISSUE, is ignored. It does not set err.
- Arithmetic is done entirely by the multiplier; the scheduler passes mul_out through unchanged.

Decomposition:
- Shared package `pq_pkg`:
  - state enum: DRAIN, IDLE, ISSUE, WAIT.
  - MUL_GAIN = 16'h08B4, MUL_SHIFT = 4.
  - DRAIN_CYC = 4.
  - channel-index width function clog2(N_REQ).
- Sub-module `rr_arbiter`: combinational round-robin pick from req_valid and last, producing a one-hot grant and an index. It is reused by later ADC/DAC sharing blocks.

Test Plan:
- Reset, then ch0 alone with req_data=0x0100:
  - no req_ready during the 4 DRAIN cycles.
  - handshake, then mul_en 1 cycle later, then res_valid[0] 5 cycles after the handshake, with res_data=0x008B40.
- All three channels valid continuously with data 0x0100, 0x8100 and 0x7FFF:
  - grants in order 0, 1, 2, 0, …
  - results 0x008B40, 0x808B40, 0x459F74.
  - each res_valid is one cycle wide, and results arrive 5 cycles apart.
- Stub multiplier that never asserts done:
  - err rises at WAIT cycle 15 and stays high.
  - no res_valid.
  - the next request is still granted.
- Stub multiplier that asserts done exactly on WAIT cycle 15: result delivered, err stays 0.
- Assert rst while in WAIT, then release it with a real multiplier that is mid-operation:
  - the stray done during DRAIN is ignored.
  - no res_valid and no err.
  - the first post-reset request completes correctly.
- ch1 valid for 1 cycle while ch0 owns the multiplier, then ch1 drops:
  - no grant is given to ch1.
  - no result for ch1.
  - busy returns low after the ch0 result.
